jtcop_vbus: RTL and testbench
=============================

// Module: jtcop_vbus
// PURPOSE
//  Parametrised register-bus hub between the main CPU, the sound/protection MCU and
//  LAYERS BAC06-style tile layers. Arbitrates per-layer CPU/MCU access, steers MCU bytes
//  onto 16-bit layer buses, registers read-back, muxes layer status bytes and latches
//  layer enables once per frame. Sits between the CPU/MCU decoders and the layer instances.
// PARAMETERS
//  LAYERS    3       number of tile layers, 1..7
//  AW        12      layer word-address width (address bits AW:1)
//  MCU_MASK  3'b100  bit i=1: MCU may access layer i (width LAYERS)
// PORTS
//  clk       in   1          system clock
//  rst       in   1          asynchronous reset, active high
//  cpu_cs    in   LAYERS     CPU layer select, one-hot expected
//  cpu_addr  in   AW         CPU word address [AW:1]
//  cpu_dout  in   16         CPU write data
//  cpu_dsn   in   2          CPU byte strobes, active low
//  cpu_rnw   in   1          CPU read/not-write
//  cpu_din   out  16         registered CPU read data
//  cpu_wait  out  1          CPU request pending, not granted
//  mcu_cs    in   LAYERS     MCU layer select
//  mcu_addr  in   10         MCU byte address
//  mcu_dout  in   8          MCU write data
//  mcu_rnw   in   1          MCU read/not-write
//  mcu_din   out  8          registered MCU read data
//  mcu_wait  out  1          MCU request pending, not granted
//  lyr_cs    out  LAYERS     per-layer access strobe
//  lyr_addr  out  LAYERS*AW  per-layer word address, layer i at [i*AW+:AW]
//  lyr_din   out  LAYERS*16  per-layer write data
//  lyr_dsn   out  LAYERS*2   per-layer byte strobes
//  lyr_rnw   out  LAYERS     per-layer read/not-write
//  lyr_dout  in   LAYERS*16  per-layer read data
//  st_addr   in   8          status address; [5:3] layer, [2:0] byte
//  lyr_st    in   LAYERS*8   per-layer status bytes, already addressed by st_addr[2:0]
//  st_dout   out  8          registered status byte
//  VS        in   1          vertical sync
//  gfx_en    in   LAYERS     requested layer enables
//  lyr_en    out  LAYERS     frame-latched layer enables
// BEHAVIOUR
//  - Reset: all grant FSMs IDLE, round-robin favours CPU, cpu_din=0, mcu_din=0, st_dout=0,
//    lyr_en=all ones, conflict counter=0; in-flight access aborted (lyr_cs drops at once).
//  - Per-layer FSM IDLE/CPU/MCU. IDLE: cpu req only -> CPU; mcu req (mask bit set) only -> MCU;
//    both same cycle -> side not granted last time, rr flips after grant. CPU/MCU held while
//    that master's cs stays high; cs low -> IDLE; pending request granted next cycle.
//  - cpu_wait=|(cpu_cs & ~cpu_granted); mcu_wait likewise; combinational, unregistered.
//  - lyr_* combinational mux of granted master; IDLE: lyr_cs=0, lyr_rnw=1, lyr_dsn=2'b11.
//  - MCU steering: lyr_addr={0, mcu_addr[9:1]}, lyr_din={2{mcu_dout}},
//    lyr_dsn = mcu_addr[0] ? 2'b01 : 2'b10.
//  - Read data: every cycle a master holds a layer, its din register loads that layer's
//    lyr_dout (MCU: byte by mcu_addr[0], 1=[15:8]); latency 1 clk after grant; otherwise holds.
//  - Multiple cpu_cs bits: lowest index granted; the rest raise cpu_wait.
//  - MCU select on a layer with mask bit 0: ignored, no wait, mcu_din loads 8'hff.
//  - st_dout registered: st_addr[5:3] < LAYERS -> lyr_st of that layer; else 8'hff.
//  - lyr_en <= gfx_en on VS rising edge only (edge detected from registered VS).
// CONFIGURATION
//  JTCOP_VBUS_CNT_EN defined: 8-bit saturating counter of cycles with both masters requesting
//    one layer; cleared on VS rising edge (clear wins over count); read at st_addr==8'hf8.
//  Not defined: no counter; st_addr 8'hf8 returns 8'hff like any out-of-range address.
// TESTING
//  - CPU write layer0 addr 12'h010 data 16'h1234 dsn 00 -> lyr_cs[0]=1 next clk, fields exact, no wait.
//  - MCU read layer2 mcu_addr 10'h021, lyr_dout2=16'hABCD -> lyr_addr 5'h10, dsn 01, mcu_din=8'hAB.
//  - CPU+MCU hit layer2 same clk -> CPU granted, mcu_wait=1 until cpu_cs low; repeat -> MCU first.
//  - MCU selects layer1 (mask 0) -> lyr_cs[1]=0, mcu_wait=0, mcu_din=8'hff.
//  - gfx_en 3'b010 mid-frame -> lyr_en stays 3'b111 until VS rise, then 3'b010.
//  - rst pulse during CPU grant -> lyr_cs=0, cpu_din=0; 10 conflict clks -> st_dout 8'h0a at 8'hf8 (CNT_EN).

Source files
------------

// File: rtl/jtcop_vbus.sv
// Register-bus hub between CPU, MCU and BAC06-style tile layers: per-layer arbitration, MCU byte steering,
// read-back and status registers, frame-latched enables. Define JTCOP_VBUS_CNT_EN to add the conflict counter.
module jtcop_vbus #(
    parameter int unsigned       LAYERS   = 3,
    parameter int unsigned       AW       = 12,
    parameter logic [LAYERS-1:0] MCU_MASK = LAYERS'(3'b100)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LAYERS-1:0]    cpu_cs,
    input  logic [AW-1:0]        cpu_addr,
    input  logic [15:0]          cpu_dout,
    input  logic [1:0]           cpu_dsn,
    input  logic                 cpu_rnw,
    output logic [15:0]          cpu_din,
    output logic                 cpu_wait,
    input  logic [LAYERS-1:0]    mcu_cs,
    input  logic [9:0]           mcu_addr,
    input  logic [7:0]           mcu_dout,
    input  logic                 mcu_rnw,
    output logic [7:0]           mcu_din,
    output logic                 mcu_wait,
    output logic [LAYERS-1:0]    lyr_cs,
    output logic [LAYERS*AW-1:0] lyr_addr,
    output logic [LAYERS*16-1:0] lyr_din,
    output logic [LAYERS*2-1:0]  lyr_dsn,
    output logic [LAYERS-1:0]    lyr_rnw,
    input  logic [LAYERS*16-1:0] lyr_dout,
    input  logic [7:0]           st_addr,
    input  logic [LAYERS*8-1:0]  lyr_st,
    output logic [7:0]           st_dout,
    input  logic                 VS,
    input  logic [LAYERS-1:0]    gfx_en,
    output logic [LAYERS-1:0]    lyr_en
);

    typedef enum logic [1:0] {IDLE, CPU, MCU} gnt_e;

    logic [LAYERS-1:0] cpu_req, mcu_req, cpu_gnt, mcu_gnt;
    logic              vs_q, vs_rise;

    // CPU only ever drives its lowest selected layer; MCU selects outside the mask are dropped
    assign cpu_req  = cpu_cs & (~cpu_cs + LAYERS'(1));
    assign mcu_req  = mcu_cs & MCU_MASK;
    assign cpu_wait = |(cpu_cs & ~cpu_gnt);
    assign mcu_wait = |(mcu_req & ~mcu_gnt);
    assign vs_rise  = VS & ~vs_q;

    for (genvar i = 0; i < LAYERS; i++) begin : g_lyr
        gnt_e        st_q, st_nx;
        logic        rr_q, rr_nx;    // 1: MCU wins the next contested grant
        logic        cs, rnw;
        logic [AW-1:0] addr;
        logic [15:0] din;
        logic [1:0]  dsn;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st_q <= IDLE;
                rr_q <= 1'b0;
            end else begin
                st_q <= st_nx;
                rr_q <= rr_nx;
            end
        end

        always_comb begin
            st_nx = st_q;
            rr_nx = rr_q;
            case (st_q)
                IDLE: begin
                    if (cpu_req[i] && mcu_req[i]) begin
                        st_nx = rr_q ? MCU : CPU;
                        rr_nx = ~rr_q;
                    end else if (cpu_req[i]) begin
                        st_nx = CPU;
                    end else if (mcu_req[i]) begin
                        st_nx = MCU;
                    end
                end
                CPU:     if (!cpu_req[i]) st_nx = IDLE;
                MCU:     if (!mcu_req[i]) st_nx = IDLE;
                default: st_nx = IDLE;
            endcase
        end

        always_comb begin
            cs   = 1'b0;
            rnw  = 1'b1;
            addr = '0;
            din  = '0;
            dsn  = 2'b11;
            if (st_q == CPU) begin
                cs   = 1'b1;
                rnw  = cpu_rnw;
                addr = cpu_addr;
                din  = cpu_dout;
                dsn  = cpu_dsn;
            end else if (st_q == MCU) begin
                cs   = 1'b1;
                rnw  = mcu_rnw;
                addr = AW'(mcu_addr[9:1]);
                din  = {2{mcu_dout}};
                dsn  = mcu_addr[0] ? 2'b01 : 2'b10;
            end
        end

        assign cpu_gnt[i]           = (st_q == CPU);
        assign mcu_gnt[i]           = (st_q == MCU);
        assign lyr_cs[i]            = cs;
        assign lyr_rnw[i]           = rnw;
        assign lyr_addr[i*AW +: AW] = addr;
        assign lyr_din[i*16 +: 16]  = din;
        assign lyr_dsn[i*2 +: 2]    = dsn;
    end

    logic        cpu_hit, mcu_hit;
    logic [15:0] cpu_rd, mcu_rd;
    logic [7:0]  st_nx;
    logic        unused_st;

    assign unused_st = ^st_addr[7:6];

    always_comb begin
        cpu_hit = 1'b0;
        mcu_hit = 1'b0;
        cpu_rd  = '0;
        mcu_rd  = '0;
        for (int i = 0; i < LAYERS; i++) begin
            if (cpu_gnt[i] && !cpu_hit) begin
                cpu_hit = 1'b1;
                cpu_rd  = lyr_dout[i*16 +: 16];
            end
            if (mcu_gnt[i] && !mcu_hit) begin
                mcu_hit = 1'b1;
                mcu_rd  = lyr_dout[i*16 +: 16];
            end
        end
    end

`ifdef JTCOP_VBUS_CNT_EN
    logic [7:0] cnt;

    // Contention cycles per frame, saturating; the frame clear takes priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  cnt <= '0;
        else if (vs_rise)                         cnt <= '0;
        else if (|(cpu_req & mcu_req) && cnt != 8'hff) cnt <= cnt + 8'd1;
    end
`endif

    always_comb begin
        st_nx = 8'hff;
        for (int i = 0; i < LAYERS; i++) begin
            if (3'(i) == st_addr[5:3]) st_nx = lyr_st[i*8 +: 8];
        end
`ifdef JTCOP_VBUS_CNT_EN
        if (st_addr == 8'hf8) st_nx = cnt;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_din <= '0;
            mcu_din <= '0;
            st_dout <= '0;
            vs_q    <= 1'b0;
            lyr_en  <= '1;
        end else begin
            if (cpu_hit) cpu_din <= cpu_rd;
            if (mcu_hit)                    mcu_din <= mcu_addr[0] ? mcu_rd[15:8] : mcu_rd[7:0];
            else if (|(mcu_cs & ~MCU_MASK)) mcu_din <= 8'hff;
            st_dout <= st_nx;
            vs_q    <= VS;
            if (vs_rise) lyr_en <= gfx_en;
        end
    end

endmodule

// File: tb/tb_jtcop_vbus.sv
// Scoreboard bench for jtcop_vbus: stimulus queues expected values tagged with a cycle, a negedge monitor checks them.
module tb_jtcop_vbus;
    localparam int unsigned LAYERS = 3;
    localparam int unsigned AW     = 12;

    localparam int S_CWAIT = 0, S_MWAIT = 1, S_CS = 2, S_CDIN = 3, S_MDIN = 4, S_ST = 5, S_EN = 6;
    localparam int S_A0 = 7, S_D0 = 8, S_DSN0 = 9, S_RNW = 10, S_A2 = 11, S_DSN2 = 12, S_D2 = 13;

    logic                 clk, rst;
    logic [LAYERS-1:0]    cpu_cs, mcu_cs, lyr_cs, lyr_rnw, gfx_en, lyr_en;
    logic [AW-1:0]        cpu_addr;
    logic [15:0]          cpu_dout, cpu_din;
    logic [1:0]           cpu_dsn;
    logic                 cpu_rnw, cpu_wait, mcu_rnw, mcu_wait, VS;
    logic [9:0]           mcu_addr;
    logic [7:0]           mcu_dout, mcu_din, st_addr, st_dout;
    logic [LAYERS*AW-1:0] lyr_addr;
    logic [LAYERS*16-1:0] lyr_din, lyr_dout;
    logic [LAYERS*2-1:0]  lyr_dsn;
    logic [LAYERS*8-1:0]  lyr_st;

    jtcop_vbus dut (
        .clk(clk), .rst(rst),
        .cpu_cs(cpu_cs), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_dsn(cpu_dsn),
        .cpu_rnw(cpu_rnw), .cpu_din(cpu_din), .cpu_wait(cpu_wait),
        .mcu_cs(mcu_cs), .mcu_addr(mcu_addr), .mcu_dout(mcu_dout), .mcu_rnw(mcu_rnw),
        .mcu_din(mcu_din), .mcu_wait(mcu_wait),
        .lyr_cs(lyr_cs), .lyr_addr(lyr_addr), .lyr_din(lyr_din), .lyr_dsn(lyr_dsn),
        .lyr_rnw(lyr_rnw), .lyr_dout(lyr_dout),
        .st_addr(st_addr), .lyr_st(lyr_st), .st_dout(st_dout),
        .VS(VS), .gfx_en(gfx_en), .lyr_en(lyr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned at;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [31:0] probe(input int sel);
        case (sel)
            S_CWAIT: return 32'(cpu_wait);
            S_MWAIT: return 32'(mcu_wait);
            S_CS:    return 32'(lyr_cs);
            S_CDIN:  return 32'(cpu_din);
            S_MDIN:  return 32'(mcu_din);
            S_ST:    return 32'(st_dout);
            S_EN:    return 32'(lyr_en);
            S_A0:    return 32'(lyr_addr[0 +: AW]);
            S_D0:    return 32'(lyr_din[0 +: 16]);
            S_DSN0:  return 32'(lyr_dsn[0 +: 2]);
            S_RNW:   return 32'(lyr_rnw);
            S_A2:    return 32'(lyr_addr[2*AW +: AW]);
            S_DSN2:  return 32'(lyr_dsn[4 +: 2]);
            S_D2:    return 32'(lyr_din[32 +: 16]);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic exp_at(input int unsigned off, input int sel, input logic [31:0] exp, input string name);
        exp_t e;
        e.at   = cyc + off;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        sbq.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: retire every expectation due this cycle, flag any that slipped past
    always @(negedge clk) begin
        for (int k = sbq.size() - 1; k >= 0; k--) begin
            if (sbq[k].at <= cyc) begin
                logic [31:0] got;
                got = probe(sbq[k].sel);
                checks++;
                if (sbq[k].at < cyc) begin
                    failures++;
                    $display("FAIL %s: expectation missed (due cycle %0d, now %0d)", sbq[k].name, sbq[k].at, cyc);
                end else if (got !== sbq[k].exp) begin
                    failures++;
                    $display("FAIL %s: got %h want %h (cycle %0d)", sbq[k].name, got, sbq[k].exp, cyc);
                end
                sbq.delete(k);
            end
        end
    end

    initial begin
        int guard;
        rst      = 1'b1;
        cpu_cs   = '0; cpu_addr = '0; cpu_dout = '0; cpu_dsn = 2'b11; cpu_rnw = 1'b1;
        mcu_cs   = '0; mcu_addr = '0; mcu_dout = 8'h5a; mcu_rnw = 1'b1;
        lyr_dout = {16'habcd, 16'h5678, 16'h9abc};
        lyr_st   = {8'h33, 8'h22, 8'h11};
        st_addr  = 8'h00;
        VS       = 1'b0;
        gfx_en   = 3'b111;
        step(2);
        rst = 1'b0;
        exp_at(0, S_CS, 0, "rst_lyr_cs");
        exp_at(0, S_CDIN, 0, "rst_cpu_din");
        exp_at(0, S_MDIN, 0, "rst_mcu_din");
        exp_at(0, S_ST, 0, "rst_st_dout");
        exp_at(0, S_EN, 3'b111, "rst_lyr_en");
        exp_at(0, S_RNW, 3'b111, "rst_lyr_rnw");
        exp_at(0, S_CWAIT, 0, "rst_cpu_wait");
        step(2);

        // CPU write to layer 0
        cpu_cs = 3'b001; cpu_addr = 12'h010; cpu_dout = 16'h1234; cpu_dsn = 2'b00; cpu_rnw = 1'b0;
        exp_at(0, S_CWAIT, 1, "cpu_wait_pre_grant");
        exp_at(1, S_CS, 3'b001, "cpu_lyr_cs");
        exp_at(1, S_CWAIT, 0, "cpu_wait_granted");
        exp_at(1, S_A0, 12'h010, "cpu_lyr_addr0");
        exp_at(1, S_D0, 16'h1234, "cpu_lyr_din0");
        exp_at(1, S_DSN0, 2'b00, "cpu_lyr_dsn0");
        exp_at(1, S_RNW, 3'b110, "cpu_lyr_rnw");
        exp_at(1, S_ST, 8'h11, "st_layer0");
        exp_at(2, S_CDIN, 16'h9abc, "cpu_din_read");
        step(3);
        cpu_cs = '0; cpu_rnw = 1'b1; cpu_dsn = 2'b11;
        exp_at(0, S_CS, 3'b001, "cpu_hold_until_edge");
        exp_at(1, S_CS, 0, "cpu_release");
        step(2);

        // MCU read from layer 2, odd then even byte
        mcu_cs = 3'b100; mcu_addr = 10'h021; mcu_rnw = 1'b1;
        exp_at(0, S_MWAIT, 1, "mcu_wait_pre_grant");
        exp_at(1, S_MWAIT, 0, "mcu_wait_granted");
        exp_at(1, S_CS, 3'b100, "mcu_lyr_cs");
        exp_at(1, S_A2, 12'h010, "mcu_lyr_addr2");
        exp_at(1, S_DSN2, 2'b01, "mcu_lyr_dsn_odd");
        exp_at(1, S_D2, 16'h5a5a, "mcu_lyr_din2");
        exp_at(1, S_RNW, 3'b111, "mcu_lyr_rnw");
        exp_at(2, S_MDIN, 8'hab, "mcu_din_hi");
        step(3);
        mcu_cs = '0;
        exp_at(1, S_CS, 0, "mcu_release");
        exp_at(1, S_MDIN, 8'hab, "mcu_din_hold");
        step(2);
        mcu_cs = 3'b100; mcu_addr = 10'h020;
        exp_at(1, S_DSN2, 2'b10, "mcu_lyr_dsn_even");
        exp_at(2, S_MDIN, 8'hcd, "mcu_din_lo");
        step(3);
        mcu_cs = '0;
        step(2);

        // Contention on layer 2: CPU first, then MCU on the next contested grant
        cpu_cs = 3'b100; cpu_addr = 12'h0aa; mcu_cs = 3'b100; mcu_addr = 10'h021;
        exp_at(1, S_CS, 3'b100, "conf1_lyr_cs");
        exp_at(1, S_CWAIT, 0, "conf1_cpu_wait");
        exp_at(1, S_MWAIT, 1, "conf1_mcu_wait");
        exp_at(1, S_A2, 12'h0aa, "conf1_cpu_addr");
        step(3);
        exp_at(0, S_MWAIT, 1, "conf1_mcu_still_waits");
        cpu_cs = '0;
        exp_at(1, S_MWAIT, 1, "conf1_mcu_wait_idle");
        exp_at(1, S_CS, 0, "conf1_idle_gap");
        exp_at(2, S_MWAIT, 0, "conf1_mcu_granted");
        exp_at(2, S_CS, 3'b100, "conf1_mcu_cs");
        exp_at(2, S_A2, 12'h010, "conf1_mcu_addr");
        step(3);
        mcu_cs = '0;
        step(2);
        cpu_cs = 3'b100; mcu_cs = 3'b100;
        exp_at(1, S_CS, 3'b100, "conf2_lyr_cs");
        exp_at(1, S_MWAIT, 0, "conf2_mcu_first");
        exp_at(1, S_CWAIT, 1, "conf2_cpu_waits");
        exp_at(1, S_A2, 12'h010, "conf2_mcu_addr");
        step(2);
        cpu_cs = '0; mcu_cs = '0;
        step(2);

        // MCU select on a masked layer
        mcu_cs = 3'b010;
        exp_at(0, S_MWAIT, 0, "masked_no_wait");
        exp_at(1, S_CS, 0, "masked_no_cs");
        exp_at(1, S_MDIN, 8'hff, "masked_mcu_din");
        step(2);
        mcu_cs = '0;
        step(1);

        // Several CPU selects: lowest wins
        cpu_cs = 3'b011;
        exp_at(1, S_CS, 3'b001, "multi_cs_lowest");
        exp_at(1, S_CWAIT, 1, "multi_cs_wait");
        step(2);
        cpu_cs = '0;
        step(2);

        // Layer enables latch only on VS rising edge
        gfx_en = 3'b010;
        exp_at(2, S_EN, 3'b111, "en_mid_frame");
        step(3);
        VS = 1'b1;
        exp_at(0, S_EN, 3'b111, "en_before_edge");
        exp_at(1, S_EN, 3'b010, "en_after_vs_rise");
        step(2);
        gfx_en = 3'b111;
        exp_at(2, S_EN, 3'b010, "en_vs_high_no_edge");
        step(3);
        VS = 1'b0;
        step(2);

        // Status byte mux
        st_addr = 8'h08; exp_at(1, S_ST, 8'h22, "st_layer1"); step(1);
        st_addr = 8'h10; exp_at(1, S_ST, 8'h33, "st_layer2"); step(1);
        st_addr = 8'h18; exp_at(1, S_ST, 8'hff, "st_layer3_oob"); step(1);
        st_addr = 8'h38; exp_at(1, S_ST, 8'hff, "st_layer7_oob"); step(1);
        st_addr = 8'h00;
        step(1);

        // Reset in the middle of a CPU grant
        cpu_cs = 3'b001;
        step(2);
        exp_at(0, S_CDIN, 16'h9abc, "pre_rst_cpu_din");
        step(1);
        rst = 1'b1; cpu_cs = '0;
        exp_at(0, S_CS, 0, "rst_abort_cs");
        exp_at(0, S_CDIN, 0, "rst_abort_cpu_din");
        exp_at(0, S_EN, 3'b111, "rst_abort_lyr_en");
        step(1);
        rst = 1'b0;
        step(1);

        // Ten contention cycles, then read the counter address
        cpu_cs = 3'b100; mcu_cs = 3'b100;
        step(10);
        cpu_cs = '0; mcu_cs = '0; st_addr = 8'hf8;
`ifdef JTCOP_VBUS_CNT_EN
        exp_at(1, S_ST, 8'h0a, "cnt_ten_conflicts");
`else
        exp_at(1, S_ST, 8'hff, "cnt_addr_absent");
`endif
        step(2);
        VS = 1'b1;
`ifdef JTCOP_VBUS_CNT_EN
        exp_at(2, S_ST, 8'h00, "cnt_clear_on_vs");
`else
        exp_at(2, S_ST, 8'hff, "cnt_addr_absent_vs");
`endif
        step(3);
        VS = 1'b0;

        guard = 0;
        while (sbq.size() != 0 && guard < 50) begin
            step(1);
            guard++;
        end
        foreach (sbq[k]) begin
            checks++;
            failures++;
            $display("FAIL %s: never checked (due cycle %0d)", sbq[k].name, sbq[k].at);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
